// File: rtl/ts_pkg.sv
// ts_pkg: shared constants, FSM state encoding and sample record for the time-surface scan controller.
// Revision: 1.0
`default_nettype none

package ts_pkg;

    localparam int GRID_SIZE_DEF = 16;
    localparam int ADDR_W        = 8;
    localparam int VALUE_W       = 8;
    localparam int NUM_CELLS     = GRID_SIZE_DEF * GRID_SIZE_DEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } scan_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [VALUE_W-1:0] value;
        logic               last;
    } scan_sample_t;

endpackage

`default_nettype wire

// File: rtl/ts_scan_fifo.sv
// ts_scan_fifo: synchronous FIFO of scan samples with occupancy count; head is shown combinationally.
// Revision: 1.0
`default_nettype none

module ts_scan_fifo
    import ts_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  scan_sample_t             i_data,
    input  logic                     i_pop,
    output scan_sample_t             o_head,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PW = $clog2(DEPTH);

    scan_sample_t    r_mem [DEPTH];
    logic [PW-1:0]   r_wr;
    logic [PW-1:0]   r_rd;
    logic [PW:0]     r_count;
    logic            w_pop;

    assign w_pop = i_pop && (r_count != '0);

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            if (i_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!i_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_head  = r_mem[r_rd];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/time_surface_scan_ctrl.sv
// time_surface_scan_ctrl: sweeps the time-surface memory, tracks 2-cycle read latency, streams samples out.
// Optional SCAN_TIMER_EN: periodic internal scan start every FRAME_PERIOD cycles. Revision: 1.0
`default_nettype none

module time_surface_scan_ctrl
    import ts_pkg::*;
#(
    parameter int GRID_SIZE  = 16,
    parameter int ADDR_BITS  = 8,
    parameter int VALUE_BITS = 8,
    parameter int FIFO_DEPTH = 4
`ifdef SCAN_TIMER_EN
    ,
    parameter int FRAME_PERIOD = 12000
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_scan_start,
    output logic                  o_scan_busy,
    output logic                  o_scan_done,
    output logic                  o_mem_rd_en,
    output logic [ADDR_BITS-1:0]  o_mem_rd_addr,
    input  logic [VALUE_BITS-1:0] i_mem_rd_value,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [ADDR_BITS-1:0]  o_out_addr,
    output logic [VALUE_BITS-1:0] o_out_value,
    output logic                  o_out_last
);

    localparam int                   CELLS     = GRID_SIZE * GRID_SIZE;
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(CELLS - 1);
    localparam int                   CW        = $clog2(FIFO_DEPTH) + 1;

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_SCAN  = SCAN;
    localparam logic [1:0] S_DRAIN = DRAIN;
    localparam logic [1:0] S_DONE  = DONE;

    logic [1:0]           r_state;
    logic [ADDR_BITS-1:0] r_addr;
    logic [1:0]           r_pv;
    logic [ADDR_BITS-1:0] r_pa0;
    logic [ADDR_BITS-1:0] r_pa1;

    logic                 w_start;
    logic [1:0]           w_inflight;
    logic [CW-1:0]        w_fifo_count;
    logic [CW:0]          w_used;
    logic                 w_issue;
    logic                 w_empty;
    logic                 w_pop;
    logic                 w_last_pop;
    scan_sample_t         w_push_data;
    scan_sample_t         w_head;

`ifdef SCAN_TIMER_EN
    localparam int TW = $clog2(FRAME_PERIOD);

    logic [TW-1:0] r_timer;
    logic          w_tick;

    assign w_tick = (r_timer == TW'(FRAME_PERIOD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer <= '0;
        end else begin
            r_timer <= w_tick ? '0 : r_timer + 1'b1;
        end
    end

    assign w_start = i_scan_start | w_tick;
`else
    assign w_start = i_scan_start;
`endif

    // Credit: buffered samples plus reads still in the latency pipe may never exceed the FIFO depth.
    assign w_inflight = {1'b0, r_pv[0]} + {1'b0, r_pv[1]};
    assign w_used     = {1'b0, w_fifo_count} + {{(CW-1){1'b0}}, w_inflight};
    assign w_issue    = (r_state == S_SCAN) && (w_used < (CW+1)'(FIFO_DEPTH));

    assign w_pop      = !w_empty && i_out_ready;
    assign w_last_pop = w_pop && w_head.last;

    assign w_push_data.addr  = r_pa1;
    assign w_push_data.value = i_mem_rd_value;
    assign w_push_data.last  = (r_pa1 == LAST_ADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_pv    <= '0;
            r_pa0   <= '0;
            r_pa1   <= '0;
        end else begin
            r_pv  <= {r_pv[0], w_issue};
            r_pa0 <= r_addr;
            r_pa1 <= r_pa0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state <= S_SCAN;
                        r_addr  <= '0;
                    end
                end
                S_SCAN: begin
                    if (w_issue) begin
                        if (r_addr == LAST_ADDR) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_addr <= r_addr + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_last_pop && (w_inflight == 2'd0)) begin
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    ts_scan_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_pv[1]),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_empty (w_empty),
        .o_count (w_fifo_count)
    );

    // The memory advances its decay stage only while read_enable is high.
    assign o_mem_rd_en   = (r_state == S_SCAN) || ((r_state == S_DRAIN) && (w_inflight != 2'd0));
    assign o_mem_rd_addr = r_addr;
    assign o_scan_busy   = (r_state != S_IDLE);
    assign o_scan_done   = (r_state == S_DONE);
    assign o_out_valid   = !w_empty;
    assign o_out_addr    = w_empty ? '0 : w_head.addr;
    assign o_out_value   = w_empty ? '0 : w_head.value;
    assign o_out_last    = !w_empty && w_head.last;

endmodule

`default_nettype wire
